// File: rtl/v_mul_seq.sv
// Vector multiply sequencer: streams operand words from the operand buffer into a
// fixed-latency multiplier and tags each word through to writeback with byte enables.
module v_mul_seq #(
  parameter int MUL_LAT = 3,
  parameter int N_WORDS = 16,
  parameter int AW      = 4
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  output logic          ready,
  input  logic [1:0]    sew,
  input  logic [7:0]    vl,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [31:0]   rd_data_a,
  input  logic [31:0]   rd_data_b,
  output logic          is_mul,
  output logic [1:0]    mul_sew,
  output logic [31:0]   mul_op_a,
  output logic [31:0]   mul_op_b,
  input  logic [31:0]   mul_result,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [31:0]   wb_data,
  output logic [3:0]    wb_be,
  output logic          done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int DEPTH = MUL_LAT + 1;
  localparam int BW    = (AW + 3 > 10) ? AW + 3 : 10;

  logic [1:0]    state, state_nx;
  logic [1:0]    sew_q;
  logic [1:0]    tail_q;
  logic [AW-1:0] wc;
  logic [AW-1:0] last_idx;
  logic          zero_done;

  logic [DEPTH-1:0]         tag_v;
  logic [DEPTH-1:0]         tag_last;
  logic [DEPTH-1:0][AW-1:0] tag_addr;
  logic [DEPTH-1:0][3:0]    tag_be;

  logic          accept;
  logic          zero_cmd;
  logic          issue;
  logic          is_last;
  logic          out_v;
  logic          drain_done;
  logic [3:0]    push_be;
  logic [BW-1:0] bytes_raw;
  logic [BW-1:0] bytes_cl;
  logic [BW-1:0] cap;
  logic [BW-1:0] n_words;

  // Byte count is clamped before rounding up to words, so an oversized VL
  // always lands on a whole-buffer transfer with no tail.
  always_comb begin
    cap       = BW'(N_WORDS) << 2;
    bytes_raw = BW'(vl) << sew;
    bytes_cl  = (bytes_raw > cap) ? cap : bytes_raw;
    n_words   = (bytes_cl + BW'(3)) >> 2;
    zero_cmd  = (vl == 8'd0) || (sew == 2'b11);
  end

  // ready stays low while a zero/illegal done is pending and while held in reset.
  assign ready      = nrst && (state == S_IDLE) && !zero_done;
  assign accept     = start && ready;
  assign issue      = (state == S_ISSUE);
  assign is_last    = (wc == last_idx);
  assign push_be    = (is_last && tail_q != 2'd0) ? ((4'b0001 << tail_q) - 4'b0001) : 4'b1111;
  assign out_v      = tag_v[DEPTH-1];
  assign drain_done = (state == S_DRAIN) && out_v && tag_last[DEPTH-1];

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept && !zero_cmd) state_nx = S_ISSUE;
      S_ISSUE: if (is_last) state_nx = S_DRAIN;
      S_DRAIN: if (drain_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      sew_q     <= '0;
      tail_q    <= '0;
      last_idx  <= '0;
      wc        <= '0;
      zero_done <= 1'b0;
    end else begin
      state     <= state_nx;
      zero_done <= accept && zero_cmd;
      if (accept) begin
        sew_q    <= sew;
        tail_q   <= bytes_cl[1:0];
        last_idx <= AW'(n_words - BW'(1));
        wc       <= '0;
      end else if (issue) begin
        wc <= wc + AW'(1);
      end
    end
  end

  // Stage 0 absorbs the operand buffer read latency, the rest track the multiplier.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tag_v    <= '0;
      tag_last <= '0;
      tag_addr <= '0;
      tag_be   <= '0;
    end else begin
      tag_v    <= {tag_v[DEPTH-2:0], issue};
      tag_last <= {tag_last[DEPTH-2:0], issue && is_last};
      tag_addr <= {tag_addr[DEPTH-2:0], wc};
      tag_be   <= {tag_be[DEPTH-2:0], push_be};
    end
  end

  assign rd_en    = issue;
  assign rd_addr  = issue ? wc : '0;
  assign is_mul   = issue || (|tag_v);
  assign mul_sew  = sew_q;
  assign mul_op_a = rd_data_a;
  assign mul_op_b = rd_data_b;
  assign wb_valid = out_v;
  assign wb_addr  = out_v ? tag_addr[DEPTH-1] : '0;
  assign wb_be    = out_v ? tag_be[DEPTH-1] : '0;
  assign wb_data  = out_v ? mul_result : '0;
  assign done     = zero_done || drain_done;

endmodule

// File: tb/tb_v_mul_seq.sv
// Bench for v_mul_seq: operand buffer and multiplier models around the DUT, with
// expected timing and writeback data derived from the instruction's VL/SEW.
module tb_v_mul_seq;

  localparam int L  = 3;
  localparam int NW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    sew = '0;
  logic [7:0]    vl = '0;
  logic          ready, rd_en, is_mul, wb_valid, done;
  logic [AW-1:0] rd_addr, wb_addr;
  logic [31:0]   rd_data_a = '0, rd_data_b = '0;
  logic [1:0]    mul_sew;
  logic [31:0]   mul_op_a, mul_op_b, mul_result, wb_data;
  logic [3:0]    wb_be;

  logic [31:0] mem_a [NW];
  logic [31:0] mem_b [NW];
  logic [31:0] mp    [L];
  logic [31:0] obs   [NW];

  int checks = 0;
  int errors = 0;

  v_mul_seq #(.MUL_LAT(L), .N_WORDS(NW), .AW(AW)) dut (
    .clk(clk), .nrst(nrst), .start(start), .ready(ready), .sew(sew), .vl(vl),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .is_mul(is_mul), .mul_sew(mul_sew), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b),
    .mul_result(mul_result), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_be(wb_be), .done(done)
  );

  always #5 clk = ~clk;

  // Lane-wise signed multiply keeping the low SEW bits of each product.
  function automatic logic [31:0] lane_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] s);
    logic [31:0] r;
    int pa, pb;
    r = '0;
    case (s)
      2'd0: for (int i = 0; i < 4; i++) begin
        pa = int'($signed(a[i*8 +: 8]));
        pb = int'($signed(b[i*8 +: 8]));
        r[i*8 +: 8] = 8'(pa * pb);
      end
      2'd1: for (int i = 0; i < 2; i++) begin
        pa = int'($signed(a[i*16 +: 16]));
        pb = int'($signed(b[i*16 +: 16]));
        r[i*16 +: 16] = 16'(pa * pb);
      end
      default: begin
        pa = int'($signed(a));
        pb = int'($signed(b));
        r  = 32'(pa * pb);
      end
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem_a[rd_addr];
      rd_data_b <= mem_b[rd_addr];
    end
  end

  always @(posedge clk) begin
    mp[0] <= lane_mul(mul_op_a, mul_op_b, mul_sew);
    for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
  end
  assign mul_result = mp[L-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < NW; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
  endtask

  // Called just after a negedge with the DUT expected idle; returns one cycle past done.
  task automatic run(input logic [1:0] s, input logic [7:0] v, input bit poke);
    int bytes, nw, tail, last, wi;
    bit zero, exp_rd, exp_wb;
    logic [3:0] be;
    zero  = (v == 8'd0) || (s == 2'b11);
    bytes = zero ? 0 : int'(v) * (1 << s);
    if (bytes > 4 * NW) bytes = 4 * NW;
    nw    = (bytes + 3) / 4;
    tail  = bytes % 4;
    last  = zero ? 1 : nw + 1 + L;
    chk("ready_pre", 32'(ready), 32'd1);
    start = 1'b1; sew = s; vl = v;
    @(posedge clk);
    #1;
    start = 1'b0; sew = 2'($urandom); vl = 8'($urandom);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      exp_rd = !zero && (k <= nw);
      wi     = k - 2 - L;
      exp_wb = !zero && (wi >= 0) && (wi < nw);
      chk($sformatf("ready k%0d", k), 32'(ready), 32'd0);
      chk($sformatf("rd_en k%0d", k), 32'(rd_en), 32'(exp_rd));
      if (exp_rd) chk($sformatf("rd_addr k%0d", k), 32'(rd_addr), 32'(k - 1));
      chk($sformatf("is_mul k%0d", k), 32'(is_mul), 32'(!zero));
      chk($sformatf("done k%0d", k), 32'(done), 32'(k == last));
      chk($sformatf("wb_valid k%0d", k), 32'(wb_valid), 32'(exp_wb));
      chk($sformatf("mul_sew k%0d", k), 32'(mul_sew), 32'(s));
      if (exp_wb) begin
        be = (wi == nw - 1 && tail != 0) ? 4'((1 << tail) - 1) : 4'b1111;
        obs[wi] = wb_data;
        chk($sformatf("wb_addr k%0d", k), 32'(wb_addr), 32'(wi));
        chk($sformatf("wb_be k%0d", k), 32'(wb_be), 32'(be));
        chk($sformatf("wb_data k%0d", k), wb_data, lane_mul(mem_a[wi], mem_b[wi], s));
      end else begin
        chk($sformatf("wb_data_idle k%0d", k), wb_data, 32'd0);
      end
      if (poke && k <= 2) begin
        start = 1'b1; sew = 2'($urandom); vl = 8'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("post_done", 32'(done), 32'd0);
    chk("post_wb", 32'(wb_valid), 32'd0);
    chk("post_is_mul", 32'(is_mul), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < L; i++) mp[i] = '0;
    fill();
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_is_mul", 32'(is_mul), 32'd0);
    chk("rst_mul_sew", 32'(mul_sew), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_be", 32'(wb_be), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // 32-bit words, known operands
    mem_a[0] = 32'd3; mem_a[1] = 32'hFFFF_FFFE; mem_a[2] = 32'h7FFF_FFFF; mem_a[3] = 32'd0;
    mem_b[0] = 32'd5; mem_b[1] = 32'd6;         mem_b[2] = 32'd2;         mem_b[3] = 32'd9;
    run(2'b10, 8'd4, 1'b0);
    chk("t1_w0", obs[0], 32'd15);
    chk("t1_w1", obs[1], 32'hFFFF_FFF4);
    chk("t1_w2", obs[2], 32'hFFFF_FFFE);
    chk("t1_w3", obs[3], 32'd0);

    // byte elements with a tail
    fill();
    mem_a[0][7:0] = 8'h80;
    mem_b[0][7:0] = 8'h02;
    run(2'b00, 8'd6, 1'b0);
    chk("t2_byte0", 32'(obs[0][7:0]), 32'd0);

    // clamped halfword run
    fill();
    run(2'b01, 8'd64, 1'b0);

    // zero and illegal
    run(2'b00, 8'd0, 1'b0);
    run(2'b11, 8'd5, 1'b0);

    // reset during DRAIN
    fill();
    chk("rst_ready_pre", 32'(ready), 32'd1);
    start = 1'b1; sew = 2'b10; vl = 8'd8;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("mid_ready", 32'(ready), 32'd0);
    chk("mid_rd_en", 32'(rd_en), 32'd0);
    chk("mid_rd_addr", 32'(rd_addr), 32'd0);
    chk("mid_is_mul", 32'(is_mul), 32'd0);
    chk("mid_mul_sew", 32'(mul_sew), 32'd0);
    chk("mid_wb_valid", 32'(wb_valid), 32'd0);
    chk("mid_wb_addr", 32'(wb_addr), 32'd0);
    chk("mid_wb_be", 32'(wb_be), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("mid_hold_wb", 32'(wb_valid), 32'd0);
    end
    nrst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("rel_ready c%0d", k), 32'(ready), 32'd1);
      chk($sformatf("rel_wb c%0d", k), 32'(wb_valid), 32'd0);
      chk($sformatf("rel_done c%0d", k), 32'(done), 32'd0);
    end
    run(2'b10, 8'd1, 1'b0);

    // start during ISSUE is ignored; next instruction back-to-back with new SEW
    fill();
    run(2'b01, 8'd10, 1'b1);
    run(2'b00, 8'd7, 1'b0);

    for (int t = 0; t < 8; t++) begin
      fill();
      run(2'($urandom_range(0, 2)), 8'($urandom_range(1, 80)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
